scl_timing_engine: RTL and testbench

Parametrised I2C SCL clock engine, the successor to the fixed-rate `scl_generator`. It produces an open-drain SCL drive from the system clock at three preset bus speeds or a runtime-programmable rate. It supports slave clock stretching with an optional timeout and a graceful stop on disable. It also emits single-cycle phase strobes (fall, low-midpoint, rise, high-midpoint) that the I2C byte/bit controller uses to change SDA in the low phase and sample it in the high phase.

---
 rtl/scl_timing_engine.sv | 149 ++++++++++++++
 tb/tb_scl_timing_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scl_timing_engine.sv
// I2C SCL clock engine: open-drain SCL drive at preset or programmable rates,
// with slave clock stretching, optional stretch timeout and phase strobes.
module scl_timing_engine #(
  parameter int CLK_FREQ_MHZ = 50,
  parameter int DIV_W        = 12,
  parameter int STRETCH_MAX  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] half_cnt,
  input  logic             scl_in,
  output logic             scl_oe,
  output logic             busy,
  output logic             fall_stb,
  output logic             low_mid_stb,
  output logic             rise_stb,
  output logic             high_mid_stb,
  output logic             stretching,
  output logic             timeout_stb,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOW     = 2'd1,
    S_RELEASE = 2'd2,
    S_HIGH    = 2'd3
  } state_t;

  localparam int SW = (STRETCH_MAX < 2) ? 1 : $clog2(STRETCH_MAX + 1);

  localparam logic [DIV_W-1:0] H_STD  = DIV_W'(CLK_FREQ_MHZ * 5);
  localparam logic [DIV_W-1:0] H_FAST = DIV_W'((CLK_FREQ_MHZ * 5) / 4);
  localparam logic [DIV_W-1:0] H_FMP  = DIV_W'(CLK_FREQ_MHZ / 2);
  localparam logic [DIV_W-1:0] H_MIN  = DIV_W'(4);
  localparam logic [SW-1:0]    S_MAX  = SW'(STRETCH_MAX);

  state_t           state, state_nxt;
  logic [DIV_W-1:0] cnt, cnt_nxt;
  logic [DIV_W-1:0] h_reg, h_nxt, h_sel;
  logic [SW-1:0]    stretch_cnt, stretch_nxt, stretch_inc;
  logic             stretching_nxt, timeout_nxt;

  always_comb begin
    h_sel = H_STD;
    unique case (mode)
      2'd0: h_sel = H_STD;
      2'd1: h_sel = H_FAST;
      2'd2: h_sel = H_FMP;
      2'd3: h_sel = (half_cnt < H_MIN) ? H_MIN : half_cnt;
    endcase
  end

  // Saturating so a disabled timeout can never wrap the counter.
  assign stretch_inc = (stretch_cnt == '1) ? stretch_cnt : stretch_cnt + 1'b1;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    h_nxt          = h_reg;
    stretch_nxt    = stretch_cnt;
    stretching_nxt = 1'b0;
    timeout_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          h_nxt     = h_sel;
        end
      end
      S_LOW: begin
        if (cnt == h_reg - 1'b1) begin
          state_nxt   = S_RELEASE;
          cnt_nxt     = '0;
          stretch_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (scl_in) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          h_nxt     = h_sel;
        end else begin
          stretch_nxt = stretch_inc;
          if (STRETCH_MAX != 0 && stretch_inc == S_MAX) begin
            timeout_nxt = 1'b1;
            state_nxt   = S_IDLE;
          end else begin
            stretching_nxt = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (cnt == h_reg - 1'b1) begin
          cnt_nxt = '0;
          if (enable) begin
            state_nxt = S_LOW;
            h_nxt     = h_sel;
          end else begin
            state_nxt = S_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so each strobe lines up
  // with the first cycle of the phase it marks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      h_reg        <= '0;
      stretch_cnt  <= '0;
      scl_oe       <= 1'b0;
      busy         <= 1'b0;
      fall_stb     <= 1'b0;
      low_mid_stb  <= 1'b0;
      rise_stb     <= 1'b0;
      high_mid_stb <= 1'b0;
      stretching   <= 1'b0;
      timeout_stb  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      h_reg        <= h_nxt;
      stretch_cnt  <= stretch_nxt;
      scl_oe       <= (state_nxt == S_LOW);
      busy         <= (state_nxt != S_IDLE);
      fall_stb     <= (state_nxt == S_LOW)  && (cnt_nxt == '0);
      low_mid_stb  <= (state_nxt == S_LOW)  && (cnt_nxt == (h_nxt >> 1));
      rise_stb     <= (state_nxt == S_HIGH) && (cnt_nxt == '0);
      high_mid_stb <= (state_nxt == S_HIGH) && (cnt_nxt == (h_nxt >> 1));
      stretching   <= stretching_nxt;
      timeout_stb  <= timeout_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_scl_timing_engine.sv
// Directed bench for scl_timing_engine at 50 MHz with a 100-cycle stretch timeout.
module tb_scl_timing_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] half_cnt;
  logic        scl_in;
  logic        hold;
  logic        scl_oe, busy, fall_stb, low_mid_stb, rise_stb, high_mid_stb;
  logic        stretching, timeout_stb;
  logic [1:0]  state_dbg;
  logic [7:0]  outs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain bus: pulled high unless the engine or the "slave" holds it low.
  assign scl_in = ~scl_oe & ~hold;
  assign outs = {scl_oe, busy, fall_stb, low_mid_stb, rise_stb, high_mid_stb,
                 stretching, timeout_stb};

  scl_timing_engine #(
    .CLK_FREQ_MHZ(50),
    .DIV_W(12),
    .STRETCH_MAX(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode(mode),
    .half_cnt(half_cnt),
    .scl_in(scl_in),
    .scl_oe(scl_oe),
    .busy(busy),
    .fall_stb(fall_stb),
    .low_mid_stb(low_mid_stb),
    .rise_stb(rise_stb),
    .high_mid_stb(high_mid_stb),
    .stretching(stretching),
    .timeout_stb(timeout_stb),
    .state_dbg(state_dbg)
  );

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return fall_stb;
      1:       return low_mid_stb;
      2:       return rise_stb;
      3:       return high_mid_stb;
      default: return timeout_stb;
    endcase
  endfunction

  // driver tasks
  task automatic wait_sig(input string tag, input int which, input int max, output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sig(which)) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    check(tag, found, 1);
  endtask

  task automatic wait_release(output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!scl_oe) begin
        found = 1'b1;
        at = cyc;
        break;
      end
    end
    check("release_seen", found, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f, f2, t, t2, r, n;
    rst = 1'b1; enable = 1'b1; mode = 2'd0; half_cnt = '0; hold = 1'b0;

    // Reset held with enable high
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_outs", outs, 0);
    check("reset_state", state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_fall", fall_stb, 1);
    check("rst_oe", scl_oe, 1);
    f = cyc;

    // Mode 0 nominal timing
    wait_sig("w_m0_lmid", 1, 300, t);
    check("m0_low_mid", t - f, 125);
    wait_sig("w_m0_rise", 2, 300, t2);
    check("m0_rise", t2 - f, 251);
    check("m0_oe_high", scl_oe, 0);
    wait_sig("w_m0_hmid", 3, 300, t);
    check("m0_high_mid", t - t2, 125);
    wait_sig("w_m0_fall", 0, 300, f2);
    check("m0_period", f2 - f, 501);

    // 40-cycle slave stretch
    hold = 1'b1;
    wait_release(r);
    n = stretching;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n += stretching;
    end
    hold = 1'b0;
    wait_sig("w_st_rise", 2, 5, t);
    check("st_rise", t - r, 41);
    n += stretching;
    check("st_count", n, 40);
    wait_sig("w_st_fall", 0, 300, f);
    check("st_high", f - t, 250);

    // Stuck-low timeout, enable dropped meanwhile
    hold = 1'b1;
    enable = 1'b0;
    wait_release(r);
    wait_sig("w_to", 4, 150, t);
    check("to_time", t - r, 100);
    check("to_busy", busy, 0);
    check("to_oe", scl_oe, 0);
    @(negedge clk);
    check("to_once", timeout_stb, 0);
    check("to_idle", busy, 0);
    hold = 1'b0;

    // Mode 2, disable mid-LOW
    mode = 2'd2;
    enable = 1'b1;
    @(negedge clk);
    check("m2_fall", fall_stb, 1);
    f = cyc;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_sig("w_m2_lmid", 1, 20, t);
    check("m2_low_mid", t - f, 12);
    wait_sig("w_m2_rise", 2, 40, t);
    check("m2_rise", t - f, 26);
    repeat (24) @(negedge clk);
    check("m2_busy_last", busy, 1);
    @(negedge clk);
    check("m2_busy_off", busy, 0);
    check("m2_oe_off", scl_oe, 0);
    n = 0;
    repeat (60) begin
      @(negedge clk);
      n += fall_stb;
    end
    check("m2_no_fall", n, 0);

    // Custom clamp, then mode change mid-LOW
    mode = 2'd3;
    half_cnt = 12'd2;
    enable = 1'b1;
    @(negedge clk);
    check("c_fall", fall_stb, 1);
    f = cyc;
    @(negedge clk);
    mode = 2'd2;
    wait_sig("w_c_lmid", 1, 10, t);
    check("c_low_mid", t - f, 2);
    wait_sig("w_c_rise", 2, 10, t2);
    check("c_rise", t2 - f, 5);
    wait_sig("w_c_hmid", 3, 40, t);
    check("c_high_mid", t - t2, 12);
    wait_sig("w_c_fall", 0, 40, f);
    check("c_high_len", f - t2, 25);
    wait_sig("w_c_rise2", 2, 40, t);
    check("c_low_len", t - f, 26);

    // Reset mid-HIGH
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", outs, 0);
    check("rst_mid_state", state_dbg, 0);

    // Mode 1 from reset
    rst = 1'b0;
    mode = 2'd1;
    @(negedge clk);
    check("m1_fall", fall_stb, 1);
    f = cyc;
    enable = 1'b0;
    wait_sig("w_m1_lmid", 1, 80, t);
    check("m1_low_mid", t - f, 31);
    wait_sig("w_m1_rise", 2, 80, t);
    check("m1_rise", t - f, 63);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
